mul_cmp_sched: RTL

MUL_CMP_SCHED -- requirements
Module: mul_cmp_sched

---
 rtl/mul_cmp_pkg.sv | 13 +
 rtl/mul_cmp_unit.sv | 33 +++
 rtl/mul_cmp_sched.sv | 110 +++++++++++
 3 files changed

// File: rtl/mul_cmp_pkg.sv
// Shared types and constants for the multiply/compare scheduler.
// The EXEC length is tied to the two pipeline stages in mul_cmp_unit.
package mul_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int EXEC_CYCLES = 2;

endpackage

// File: rtl/mul_cmp_unit.sv
// Two-stage unsigned multiply with zero-compare select.
// Both stages advance only while en is high, so outputs hold afterwards.
module mul_cmp_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  input  logic [W-1:0] h,
  input  logic         g,
  output logic [W-1:0] prod,
  output logic         f
);

  logic [W-1:0] p1;
  logic         g1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1   <= '0;
      g1   <= 1'b0;
      prod <= '0;
      f    <= 1'b0;
    end else if (en) begin
      p1   <= d * h;
      g1   <= g;
      prod <= p1;
      f    <= (p1 == '0) ? g1 : 1'b0;
    end
  end

endmodule

// File: rtl/mul_cmp_sched.sv
// Round-robin scheduler feeding one shared multiply/compare unit.
// One operation in flight: IDLE grants, EXEC computes, RESP waits.
module mul_cmp_sched
  import mul_cmp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*W-1:0]         req_d,
  input  logic [N_REQ*W-1:0]         req_h,
  input  logic [N_REQ-1:0]           req_g,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [W-1:0]               rsp_prod,
  output logic                       rsp_f,
  output logic                       busy,
  output logic [15:0]                op_count
);

  localparam int IW = $clog2(N_REQ);

  state_t        state, state_n;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win_id;
  logic [IW-1:0] idx;
  logic          win_any;
  logic          grant;
  logic          hs;
  logic [1:0]    cnt;
  logic [W-1:0]  d_q, h_q;
  logic          g_q;

  // Scan from the far end so the nearest valid at/after rr_ptr wins.
  always_comb begin
    win_any = 1'b0;
    win_id  = rr_ptr;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = rr_ptr + IW'(k);
      if (req_valid[idx]) begin
        win_any = 1'b1;
        win_id  = idx;
      end
    end
  end

  assign grant = rst_n && (state == IDLE) && win_any;
  assign hs    = (state == RESP) && rsp_ready;

  assign req_ready = grant
    ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_id)
    : '0;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (grant) state_n = EXEC;
      EXEC: if (cnt == 2'(EXEC_CYCLES - 1))
              state_n = RESP;
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      op_count <= '0;
      rsp_id   <= '0;
      d_q      <= '0;
      h_q      <= '0;
      g_q      <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state == EXEC) ? cnt + 2'd1 : 2'd0;
      if (grant) begin
        d_q    <= req_d[win_id*W +: W];
        h_q    <= req_h[win_id*W +: W];
        g_q    <= req_g[win_id];
        rsp_id <= win_id;
      end
      if (hs) begin
        rr_ptr   <= rsp_id + 1'b1;
        op_count <= op_count + 16'd1;
      end
    end
  end

  mul_cmp_unit #(.W(W)) u_unit (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == EXEC),
    .d     (d_q),
    .h     (h_q),
    .g     (g_q),
    .prod  (rsp_prod),
    .f     (rsp_f)
  );

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule
